// File: rtl/car_sys_param.sv
// Vehicle safety/access controller: passcode unlock with retry lockout, ultrasonic
// obstacle inhibit with clear-time hysteresis, fire-alarm override, bargraph and buzzer.
module car_sys_param #(
   parameter int                N_US      = 2,
   parameter int                PASS_W    = 4,
   parameter logic [PASS_W-1:0] PASS_KEY  = 4'hA,
   parameter int                MAX_TRIES = 3,
   parameter int                LOCK_CYC  = 1000,
   parameter int                CLR_CYC   = 16,
   parameter int                BUZZ_DIV  = 50,
   parameter int                PROX_W    = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_US-1:0]   US,
   input  logic              FA,
   input  logic [PASS_W-1:0] pass,
   input  logic              enter,
   output logic [PROX_W-1:0] prox,
   output logic              buzz,
   output logic [2:0]        state_o,
   output logic              unlock
);

   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int LOCK_W = $clog2(LOCK_CYC + 1);
   localparam int CLR_W  = $clog2(CLR_CYC + 1);
   localparam int DIV_W  = $clog2(2 * BUZZ_DIV + 1);

   localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYC - 1);
   localparam logic [DIV_W-1:0]  DIV_STOP  = DIV_W'(BUZZ_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_DEN   = DIV_W'(2 * BUZZ_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_DENIED  = 3'd2,
      S_GRANTED = 3'd3,
      S_STOP    = 3'd4,
      S_EMERG   = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [N_US-1:0]     r_us_s1, r_us_s2;
   logic                r_fa_s1, r_fa_s2;
   logic [PASS_W-1:0]   r_pass_q;
   logic [TRY_W-1:0]    r_tries;
   logic [LOCK_W-1:0]   r_lock_cnt;
   logic [CLR_W-1:0]    r_clr_cnt;
   logic [DIV_W-1:0]    r_div_cnt;
   logic [PROX_W-1:0]   r_prox;
   logic                r_buzz;
   logic                w_obst;
   logic [DIV_W-1:0]    w_div_last;

   // Thermometer of active channel count, saturated at the bargraph width
   function automatic logic [PROX_W-1:0] thermo(input logic [N_US-1:0] v);
      int                cnt;
      logic [PROX_W-1:0] t;
      cnt = 0;
      for (int i = 0; i < N_US; i++) cnt += int'(v[i]);
      if (cnt > PROX_W) cnt = PROX_W;
      for (int k = 0; k < PROX_W; k++) t[k] = (cnt > k);
      return t;
   endfunction

   always_comb begin
      w_next     = S_IDLE;
      w_obst     = |r_us_s2;
      w_div_last = (r_state == S_STOP) ? DIV_STOP : DIV_DEN;
      if (r_fa_s2) begin
         w_next = S_EMERG;
      end else begin
         case (r_state)
            S_IDLE:    w_next = enter ? S_WAIT : S_IDLE;
            S_WAIT:    w_next = (r_pass_q == PASS_KEY) ? S_GRANTED :
                                (r_tries == TRY_LAST)  ? S_DENIED  : S_IDLE;
            S_DENIED:  w_next = (r_lock_cnt == LOCK_LAST) ? S_IDLE : S_DENIED;
            S_GRANTED: w_next = w_obst ? S_STOP : (enter ? S_IDLE : S_GRANTED);
            S_STOP:    w_next = (!w_obst && r_clr_cnt == CLR_LAST) ? S_GRANTED : S_STOP;
            S_EMERG:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_us_s1    <= '0;
         r_us_s2    <= '0;
         r_fa_s1    <= 1'b0;
         r_fa_s2    <= 1'b0;
         r_pass_q   <= '0;
         r_tries    <= '0;
         r_lock_cnt <= '0;
         r_clr_cnt  <= '0;
         r_div_cnt  <= '0;
         r_prox     <= '0;
         r_buzz     <= 1'b0;
      end else begin
         r_us_s1 <= US;
         r_us_s2 <= r_us_s1;
         r_fa_s1 <= FA;
         r_fa_s2 <= r_fa_s1;

         if (r_state == S_IDLE && w_next == S_WAIT) r_pass_q <= pass;

         // A fire alarm during WAIT leaves the retry count untouched
         if (r_state == S_WAIT && !r_fa_s2) begin
            if (r_pass_q == PASS_KEY || r_tries == TRY_LAST) r_tries <= '0;
            else                                              r_tries <= r_tries + TRY_W'(1);
         end else if (r_state == S_EMERG && !r_fa_s2) begin
            r_tries <= '0;
         end

         if (w_next == S_DENIED && r_state == S_DENIED) r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
         else                                           r_lock_cnt <= '0;

         if (w_next == S_STOP && r_state == S_STOP && !w_obst) r_clr_cnt <= r_clr_cnt + CLR_W'(1);
         else                                                  r_clr_cnt <= '0;

         // Buzzer divider restarts, with buzz high, on every entry to a toggling state
         if (w_next == r_state && (w_next == S_STOP || w_next == S_DENIED)) begin
            if (r_div_cnt == w_div_last) begin
               r_div_cnt <= '0;
               r_buzz    <= ~r_buzz;
            end else begin
               r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
         end else begin
            r_div_cnt <= '0;
            r_buzz    <= (w_next == S_STOP) || (w_next == S_DENIED) || (w_next == S_EMERG);
         end

         if (w_next == S_GRANTED || w_next == S_STOP) r_prox <= thermo(r_us_s2);
         else if (w_next == S_EMERG)                  r_prox <= '1;
         else                                         r_prox <= '0;
      end
   end

   assign prox    = r_prox;
   assign buzz    = r_buzz;
   assign state_o = r_state;
   assign unlock  = (r_state == S_GRANTED) || (r_state == S_STOP);

endmodule
